// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field constants and unpacked-operand type
// Purpose: shared constants and the unpack/flush helper for the fp32 adder.
// Ports: none (package).
package fp32_pkg;
   localparam int          EXP_W   = 8;
   localparam int          FRAC_W  = 23;
   localparam int          BIAS    = 127;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W:0]   sig;   // hidden bit included
   } fp_unpacked_t;

   // Denormals (exp==0) become zero regardless of fraction; the sign
   // passed in is the operand's effective sign.
   function automatic fp_unpacked_t unpack_flush(input logic [31:0] x,
                                                 input logic eff_sign);
      fp_unpacked_t u;
      u.sign = eff_sign;
      if (x[30:23] == 8'h00) begin
         u.exp = '0;
         u.sig = '0;
      end else begin
         u.exp = x[30:23];
         u.sig = {1'b1, x[22:0]};
      end
      return u;
   endfunction
endpackage

// File: rtl/addition_subtraction_if.sv
// rtl/addition_subtraction_if.sv - operand/result bundle for the fp32 adder
// Purpose: groups the operand, op-select and registered result signals.
// Ports (signals):
//   a_operand[31:0], b_operand[31:0]  binary32 operands
//   AddBar_Sub                        0: A+B, 1: A-B
//   Exception                         special-case flag (registered)
//   result[31:0]                      binary32 result (registered)
interface addition_subtraction_if;
   logic [31:0] a_operand;
   logic [31:0] b_operand;
   logic        AddBar_Sub;
   logic        Exception;
   logic [31:0] result;

   modport master (output a_operand, b_operand, AddBar_Sub,
                   input  Exception, result);
   modport slave  (input  a_operand, b_operand, AddBar_Sub,
                   output Exception, result);
endinterface

// File: rtl/lzc27.sv
// rtl/lzc27.sv - leading-zero counter for the 27-bit {sig,G,R,S} difference
// Purpose: combinational count of leading zeros; all-zero input gives 27.
// Ports:
//   value[26:0]  input   vector to scan from bit 26 down
//   count[4:0]   output  number of leading zeros
module lzc27 (
   input  logic [26:0] value,
   output logic [4:0]  count
);
   logic found;

   always_comb begin
      count = 5'd27;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && value[i]) begin
            count = 5'(26 - i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/addition_subtraction.sv
// rtl/addition_subtraction.sv - binary32 add/sub, RTZ, FTZ, registered output
// Purpose: result = A+B or A-B, truncating rounding, denormals flushed,
//          special operands flagged on Exception. One cycle latency.
// Ports:
//   clk    input  rising-edge clock
//   rst_n  input  asynchronous active-low reset (clears result/Exception)
//   bus    slave  operands, op select, registered result and Exception
module addition_subtraction
   import fp32_pkg::*;
(
   input logic                   clk,
   input logic                   rst_n,
   addition_subtraction_if.slave bus
);
   fp_unpacked_t op_a;
   fp_unpacked_t op_b;
   fp_unpacked_t big;
   logic        sign_b_eff;
   logic        eff_sub;
   logic        swap;
   logic        same_mag;
   logic        a_special;
   logic        b_special;
   logic        a_nan;
   logic        b_nan;
   logic [7:0]  small_exp;
   logic [7:0]  exp_diff;
   logic [23:0] small_sig;
   logic [4:0]  shift_amt;
   logic [4:0]  lz;
   logic [53:0] align_wide;
   logic [26:0] big_ext;
   logic [26:0] small_ext;
   logic [26:0] diff;
   logic [24:0] sum;
   logic [8:0]  exp_add;
   logic [7:0]  exp_sub;
   logic [22:0] frac_add;
   logic [22:0] frac_sub;
   logic        sub_underflow;
   logic [31:0] next_result;
   logic        next_exc;

   // B carries its effective sign from here on, so A-B is just A+(-B).
   assign sign_b_eff = bus.b_operand[31] ^ bus.AddBar_Sub;
   assign eff_sub    = bus.a_operand[31] ^ sign_b_eff;

   assign op_a = unpack_flush(bus.a_operand, bus.a_operand[31]);
   assign op_b = unpack_flush(bus.b_operand, sign_b_eff);

   assign a_special = (bus.a_operand[30:23] == EXP_MAX);
   assign b_special = (bus.b_operand[30:23] == EXP_MAX);
   assign a_nan     = a_special && (bus.a_operand[22:0] != '0);
   assign b_nan     = b_special && (bus.b_operand[22:0] != '0);

   // Magnitude ordering on the flushed operands.
   assign swap      = {op_b.exp, op_b.sig} >  {op_a.exp, op_a.sig};
   assign same_mag  = {op_b.exp, op_b.sig} == {op_a.exp, op_a.sig};
   assign big       = swap ? op_b : op_a;
   assign small_exp = swap ? op_a.exp : op_b.exp;
   assign small_sig = swap ? op_a.sig : op_b.sig;

   // Alignment: shifts of 27 or more push everything into sticky, so the
   // shift is clamped at 27. The low 27 bits of the wide shift are the
   // bits lost past S and collapse into it.
   assign exp_diff   = big.exp - small_exp;
   assign shift_amt  = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
   assign align_wide = {small_sig, 30'd0} >> shift_amt;
   assign small_ext  = {align_wide[53:28], align_wide[27] | (|align_wide[26:0])};
   assign big_ext    = {big.sig, 3'b000};

   // Add: big has zero G/R/S, so no carry comes out of the low three bits
   // and truncation can work on the 24-bit aligned significands directly.
   assign sum      = {1'b0, big.sig} + {1'b0, small_ext[26:3]};
   assign exp_add  = {1'b0, big.exp} + {8'd0, sum[24]};
   assign frac_add = sum[24] ? sum[23:1] : sum[22:0];

   // Subtract with G/R/S in play so a sticky borrow pulls the truncated
   // result below the big operand.
   assign diff = big_ext - small_ext;

   lzc27 u_lzc (
      .value (diff),
      .count (lz)
   );

   assign frac_sub      = 23'((diff << lz) >> 3);
   assign exp_sub       = big.exp - {3'd0, lz};
   assign sub_underflow = ({3'd0, lz} >= big.exp);

   always_comb begin
      next_result = '0;
      next_exc    = 1'b0;
      if (a_special || b_special) begin
         next_exc = 1'b1;
         if (a_nan || b_nan || (a_special && b_special && eff_sub))
            next_result = QNAN;
         else if (a_special)
            next_result = {bus.a_operand[31], POS_INF[30:0]};
         else
            next_result = {sign_b_eff, POS_INF[30:0]};
      end else if (eff_sub && same_mag) begin
         next_result = '0;
      end else if (big.exp == 8'd0) begin
         // Both zero with matching effective signs.
         next_result = {big.sign, 31'd0};
      end else if (!eff_sub) begin
         if (exp_add >= 9'd255) begin
            next_result = {big.sign, POS_INF[30:0]};
            next_exc    = 1'b1;
         end else begin
            next_result = {big.sign, exp_add[7:0], frac_add};
         end
      end else if (sub_underflow) begin
         next_result = {big.sign, 31'd0};
      end else begin
         next_result = {big.sign, exp_sub, frac_sub};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result    <= '0;
         bus.Exception <= 1'b0;
      end else begin
         bus.result    <= next_result;
         bus.Exception <= next_exc;
      end
   end
endmodule

// File: tb/tb_addition_subtraction.sv
// tb/tb_addition_subtraction.sv - self-checking bench for addition_subtraction
module tb_addition_subtraction;
   import fp32_pkg::*;

   logic clk;
   logic rst_n;

   addition_subtraction_if bus ();

   addition_subtraction dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   vec_t vecs[$];

   task automatic check32(input string name, input logic [31:0] got,
                          input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h required %h", name, got, want);
   endtask

   task automatic check1(input string name, input logic got, input logic want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %b required %b", name, got, want);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sub);
      @(negedge clk);
      bus.a_operand  = a;
      bus.b_operand  = b;
      bus.AddBar_Sub = sub;
      @(posedge clk);
      #1;
   endtask

   function automatic real f2r(input logic [31:0] f);
      logic [10:0] de;
      de = 11'(f[30:23]) + 11'(1023 - BIAS);
      return $bitstoreal({f[31], de, f[22:0], 29'd0});
   endfunction

   // Exact sum via TwoSum (s + err is the exact value), then truncation
   // toward zero into binary32 with flush-to-zero and overflow to Inf.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic sub, output logic [31:0] res,
                                     output logic exc);
      real x, y, s, bb, err;
      logic [63:0] d;
      int fe;
      logic sgn;
      x = f2r(a);
      y = f2r(b);
      if (sub) y = -y;
      s   = x + y;
      bb  = s - x;
      err = (x - (s - bb)) + (y - bb);
      exc = 1'b0;
      if (s == 0.0) begin
         res = 32'h0;
         return;
      end
      d   = $realtobits(s);
      sgn = d[63];
      fe  = int'(d[62:52]) - 1023 + BIAS;
      if (fe >= 255) begin
         res = {sgn, 8'hFF, 23'd0};
         exc = 1'b1;
      end else if (fe <= 0) begin
         res = {sgn, 31'd0};
      end else begin
         res = {sgn, 8'(fe), d[51:29]};
         if (d[28:0] == 29'd0 && err != 0.0 && ((err < 0.0) != sgn)) begin
            res[30:0] = res[30:0] - 31'd1;
            if (res[30:23] == 8'd0) res = {sgn, 31'd0};
         end
      end
   endfunction

   function automatic logic [31:0] rand_normal(input int e);
      return {1'($urandom), 8'(e), 23'($urandom)};
   endfunction

   initial begin
      logic [31:0] ra, rb, er;
      logic        ee;
      int          ea, eb;

      rst_n          = 1'b0;
      bus.a_operand  = 32'h3F800000;
      bus.b_operand  = 32'h3F800000;
      bus.AddBar_Sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check32("reset_result", bus.result, 32'h0);
      check1("reset_exception", bus.Exception, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back({32'h415EB852, 32'h40DEB852, 1'b0, 32'h41A70A3D, 1'b0});
      vecs.push_back({32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0});
      vecs.push_back({32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0});
      vecs.push_back({32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0});
      vecs.push_back({32'h3F800000, 32'h33000000, 1'b1, 32'h3F7FFFFF, 1'b0});
      vecs.push_back({32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1});
      vecs.push_back({32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 1'b0});
      vecs.push_back({32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1});
      vecs.push_back({32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1});
      vecs.push_back({32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1});
      vecs.push_back({32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0});
      vecs.push_back({32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0});
      vecs.push_back({32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0});
      vecs.push_back({32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0});
      vecs.push_back({32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b1});
      vecs.push_back({32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b1});
      vecs.push_back({32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0});
      vecs.push_back({32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0});
      vecs.push_back({32'h3F800000, 32'h30000000, 1'b1, 32'h3F7FFFFF, 1'b0});
      vecs.push_back({32'h3F800000, 32'h30000000, 1'b0, 32'h3F800000, 1'b0});
      vecs.push_back({32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1});
      vecs.push_back({32'h3F800000, 32'h00400000, 1'b1, 32'h3F800000, 1'b0});
      vecs.push_back({32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0});

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub);
         check32($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
         check1($sformatf("vec%0d_exception", i), bus.Exception, vecs[i].exc);
      end

      for (int i = 0; i < 5000; i++) begin
         ea = int'($urandom_range(254, 1));
         if ($urandom_range(3, 0) == 0) begin
            eb = int'($urandom_range(254, 1));
         end else begin
            eb = ea + int'($urandom_range(60, 0)) - 30;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
         end
         ra = rand_normal(ea);
         rb = rand_normal(eb);
         if ($urandom_range(15, 0) == 0) rb = {1'($urandom), ra[30:0]};
         for (int s = 0; s < 2; s++) begin
            run_op(ra, rb, 1'(s));
            ref_model(ra, rb, 1'(s), er, ee);
            check32($sformatf("rand%0d_op%0d_result a=%h b=%h", i, s, ra, rb),
                    bus.result, er);
            check1($sformatf("rand%0d_op%0d_exception a=%h b=%h", i, s, ra, rb),
                   bus.Exception, ee);
         end
      end

      run_op(32'h3F800000, 32'h3F800000, 1'b0);
      check32("stream0_result", bus.result, 32'h40000000);
      run_op(32'h40400000, 32'h3F800000, 1'b0);
      check32("stream1_result", bus.result, 32'h40800000);
      run_op(32'h7F800000, 32'h3F800000, 1'b0);
      check1("stream2_exception", bus.Exception, 1'b1);

      @(negedge clk);
      bus.a_operand  = 32'h40A00000;
      bus.b_operand  = 32'h3F800000;
      bus.AddBar_Sub = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check32("rst_async_result", bus.result, 32'h0);
      check1("rst_async_exception", bus.Exception, 1'b0);
      @(posedge clk);
      #1;
      check32("rst_held_result", bus.result, 32'h0);
      check1("rst_held_exception", bus.Exception, 1'b0);

      @(negedge clk);
      rst_n          = 1'b1;
      bus.a_operand  = 32'h3F800000;
      bus.b_operand  = 32'h40000000;
      bus.AddBar_Sub = 1'b0;
      #1;
      check32("rst_release_idle_result", bus.result, 32'h0);
      @(posedge clk);
      #1;
      check32("rst_first_op_result", bus.result, 32'h40400000);
      check1("rst_first_op_exception", bus.Exception, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
